// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: bus word type and register map.
package gpio_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [ADDR_W-1:0] GPIO_DATA_IN_OFS  = 5'h00;
    localparam logic [ADDR_W-1:0] GPIO_DATA_OUT_OFS = 5'h04;
    localparam logic [ADDR_W-1:0] GPIO_IRQ_EN_OFS   = 5'h08;
    localparam logic [ADDR_W-1:0] GPIO_EDGE_SEL_OFS = 5'h0C;
    localparam logic [ADDR_W-1:0] GPIO_IRQ_PEND_OFS = 5'h10;

    // Byte address to word-aligned register offset (low two bits are don't-care).
    function automatic logic [ADDR_W-1:0] word_ofs(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input channel: multi-flop synchroniser, debounce counter, accepted level
// and single-cycle rise/fall pulses coincident with the edge that updates the level.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_sys_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_c;
    logic                   accept_c;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    assign sync_c = sync_q[SYNC_STAGES-1];

    // A new level is accepted only after it has differed from stable for DEBOUNCE_CYCLES cycles.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept_c = 1'b0;
        if (sync_c == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_c;
            cnt_d    = '0;
            accept_c = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_c_o = accept_c & sync_c;
    assign fall_c_o = accept_c & ~sync_c;

endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO peripheral: debounced inputs, registered outputs, edge-selectable
// per-channel interrupts, single-cycle req/ack register interface.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_GPIO        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                clk_sys_i,
    input  logic                rst_i,
    input  logic [NUM_GPIO-1:0] gpio_i,
    output logic [NUM_GPIO-1:0] gpio_o,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                ack_o,
    output logic                irq_o
);

    logic [NUM_GPIO-1:0] stable_c, rise_c, fall_c, set_c, clr_c;
    logic [NUM_GPIO-1:0] data_out_q, data_out_d;
    logic [NUM_GPIO-1:0] irq_en_q, irq_en_d;
    logic [NUM_GPIO-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_GPIO-1:0] irq_pend_q, irq_pend_d;
    logic [NUM_GPIO-1:0] wdata_c;
    logic [ADDR_W-1:0]   ofs_c;
    word_t               rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                unused_c;

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_ch
        gpio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_sys_i(clk_sys_i),
            .rst_i    (rst_i),
            .pin_i    (gpio_i[i]),
            .stable_o (stable_c[i]),
            .rise_c_o (rise_c[i]),
            .fall_c_o (fall_c[i])
        );
    end

    assign ofs_c    = word_ofs(addr_i);
    assign wdata_c  = wdata_i[NUM_GPIO-1:0];
    assign unused_c = ^{addr_i[1:0], wdata_i};
    assign set_c    = (~edge_sel_q & rise_c) | (edge_sel_q & fall_c);

    // Register writes, W1C and read mux; reads capture state before this edge's updates.
    always_comb begin
        data_out_d = data_out_q;
        irq_en_d   = irq_en_q;
        edge_sel_d = edge_sel_q;
        clr_c      = '0;
        rdata_d    = '0;
        ack_d      = req_i;
        if (req_i && we_i) begin
            unique case (ofs_c)
                GPIO_DATA_OUT_OFS: data_out_d = wdata_c;
                GPIO_IRQ_EN_OFS:   irq_en_d   = wdata_c;
                GPIO_EDGE_SEL_OFS: edge_sel_d = wdata_c;
                GPIO_IRQ_PEND_OFS: clr_c      = wdata_c;
                default: ;
            endcase
        end
        if (req_i && !we_i) begin
            unique case (ofs_c)
                GPIO_DATA_IN_OFS:  rdata_d = DATA_W'(stable_c);
                GPIO_DATA_OUT_OFS: rdata_d = DATA_W'(data_out_q);
                GPIO_IRQ_EN_OFS:   rdata_d = DATA_W'(irq_en_q);
                GPIO_EDGE_SEL_OFS: rdata_d = DATA_W'(edge_sel_q);
                GPIO_IRQ_PEND_OFS: rdata_d = DATA_W'(irq_pend_q);
                default:           rdata_d = '0;
            endcase
        end
        // A fresh edge wins over a simultaneous clear of the same bit.
        irq_pend_d = (irq_pend_q & ~clr_c) | set_c;
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            data_out_q <= '0;
            irq_en_q   <= '0;
            edge_sel_q <= '0;
            irq_pend_q <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            irq_en_q   <= irq_en_d;
            edge_sel_q <= edge_sel_d;
            irq_pend_q <= irq_pend_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
        end
    end

    assign gpio_o  = data_out_q;
    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign irq_o   = |(irq_pend_q & irq_en_q);

endmodule
